seq_matrix_scan: RTL

Display stage for the 8x8 LED matrix, directly downstream of the 4-bit sequence generator. It captures each new 4-bit sequence value on the generator's clock-enable strobe and renders it as a hex glyph from an internal font ROM. It drives the matrix row by row with per-row PWM brightness. Value changes are deferred to frame boundaries, so a glyph never tears mid-frame.

---
 rtl/seq_matrix_scan_if.sv | 23 ++
 rtl/seq_matrix_scan.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seq_matrix_scan_if.sv
// Purpose : signal bundle between the sequence generator / controller side and
//           the 8x8 LED matrix scan stage.
// Ports   : val/load/bright/blank toward the scanner; row_n/col/frame_start back.
//           master = controller side, slave = seq_matrix_scan.
interface seq_matrix_scan_if;
  logic [3:0] val;          // sequence value from the generator
  logic       load;         // one-cycle capture strobe (generator CE)
  logic [2:0] bright;       // 0 = 1/8 duty .. 7 = 8/8 duty
  logic       blank;        // forces rows off and columns to 0
  logic [7:0] row_n;        // one-hot active-low row select
  logic [7:0] col;          // column pixels, bit 7 = leftmost
  logic       frame_start;  // pulse on first output cycle of row 0

  modport master (
    output val, load, bright, blank,
    input  row_n, col, frame_start
  );

  modport slave (
    input  val, load, bright, blank,
    output row_n, col, frame_start
  );
endinterface

// File: rtl/seq_matrix_scan.sv
// Purpose : renders the latest 4-bit sequence value as a hex glyph on an 8x8 matrix, row-scanned with per-row PWM.
// Latency : outputs registered, one cycle after the counter state they describe; loads appear at the next frame.
// Backpressure: none; free-running scan, load is a strobe that is always accepted (last load in a frame wins).
// Ports   : clk, rst (async, active-high); io_mx slave modport carrying val/load/bright/blank in,
//           row_n/col/frame_start out.
module seq_matrix_scan #(
  parameter int unsigned SLOT_LEN = 125
) (
  input  logic               clk,
  input  logic               rst,
  seq_matrix_scan_if.slave   io_mx
);

  localparam int unsigned CW = (SLOT_LEN < 2) ? 1 : $clog2(SLOT_LEN);

  logic [CW-1:0] r_slot_cnt;
  logic [2:0]    r_slot;
  logic [2:0]    r_row;
  logic [3:0]    r_shown;
  logic [3:0]    r_pending;
  logic          r_pend_valid;
  logic [2:0]    r_bright_q;
  logic [7:0]    r_row_n;
  logic [7:0]    r_col;
  logic          r_frame_start;

  logic          w_slot_end;
  logic          w_row_end;
  logic          w_frame_end;
  logic          w_row_start;
  logic          w_active;
  logic [63:0]   w_glyph;
  logic [7:0]    w_font_row;

  // Glyph k as 8 bytes, pixel row 0 in the most significant byte.
  // Pixels live in bits 5..1; rows 0 and 7 are always blank.
  function automatic logic [63:0] font_glyph(input logic [3:0] k);
    logic [63:0] g;
    g = '0;
    case (k)
      4'h0: g = 64'h00_1C_22_22_22_22_1C_00;
      4'h1: g = 64'h00_08_18_08_08_08_1C_00;
      4'h2: g = 64'h00_1C_22_04_08_10_3E_00;
      4'h3: g = 64'h00_3C_02_1C_02_02_3C_00;
      4'h4: g = 64'h00_04_0C_14_3E_04_04_00;
      4'h5: g = 64'h00_3E_20_3C_02_02_3C_00;
      4'h6: g = 64'h00_1C_20_3C_22_22_1C_00;
      4'h7: g = 64'h00_3E_02_04_08_10_10_00;
      4'h8: g = 64'h00_1C_22_1C_22_22_1C_00;
      4'h9: g = 64'h00_1C_22_22_1E_02_1C_00;
      4'hA: g = 64'h00_1C_22_22_3E_22_22_00;
      4'hB: g = 64'h00_3C_22_3C_22_22_3C_00;
      4'hC: g = 64'h00_1C_22_20_20_22_1C_00;
      4'hD: g = 64'h00_3C_22_22_22_22_3C_00;
      4'hE: g = 64'h00_3E_20_3C_20_20_3E_00;
      4'hF: g = 64'h00_3E_20_3C_20_20_20_00;
      default: g = '0;
    endcase
    return g;
  endfunction

  assign w_slot_end  = (r_slot_cnt == CW'(SLOT_LEN - 1));
  assign w_row_end   = w_slot_end && (r_slot == 3'd7);
  assign w_frame_end = w_row_end && (r_row == 3'd7);
  assign w_row_start = (r_slot_cnt == '0) && (r_slot == 3'd0);

  assign w_glyph    = font_glyph(r_shown);
  // ~r_row == 7 - r_row: byte index counted from the LSB end
  assign w_font_row = w_glyph[{~r_row, 3'b000} +: 8];

  // Slot 0 is always lit, so using the previous row's bright_q on the
  // row-start cycle itself is harmless.
  assign w_active = (r_slot <= r_bright_q) && !io_mx.blank;

  // Cascaded scan counters; slot and row wrap naturally at 3 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_cnt <= '0;
      r_slot     <= 3'd0;
      r_row      <= 3'd0;
    end else if (w_slot_end) begin
      r_slot_cnt <= '0;
      r_slot     <= r_slot + 3'd1;
      if (w_row_end) begin
        r_row <= r_row + 3'd1;
      end
    end else begin
      r_slot_cnt <= r_slot_cnt + CW'(1);
    end
  end

  // Value capture with frame-boundary update so a glyph never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shown      <= 4'd0;
      r_pending    <= 4'd0;
      r_pend_valid <= 1'b0;
    end else if (w_frame_end) begin
      if (io_mx.load) begin
        r_shown <= io_mx.val;
      end else if (r_pend_valid) begin
        r_shown <= r_pending;
      end
      r_pend_valid <= 1'b0;
    end else if (io_mx.load) begin
      r_pending    <= io_mx.val;
      r_pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bright_q <= 3'd0;
    end else if (w_row_start) begin
      r_bright_q <= io_mx.bright;
    end
  end

  // col shares the register stage with row_n, so an inactive row never
  // carries stale column data (no ghosting without a dead cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_n       <= 8'hFF;
      r_col         <= 8'h00;
      r_frame_start <= 1'b0;
    end else begin
      r_row_n       <= w_active ? ~(8'h01 << r_row) : 8'hFF;
      r_col         <= w_active ? w_font_row : 8'h00;
      r_frame_start <= w_row_start && (r_row == 3'd0);
    end
  end

  assign io_mx.row_n       = r_row_n;
  assign io_mx.col         = r_col;
  assign io_mx.frame_start = r_frame_start;

endmodule
